// File: rtl/inst_fetch_pkg.sv
// Shared types and address-split helpers for the way0 instruction-fetch responder.
package inst_fetch_pkg;

  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESP
  } fetch_state_e;

  // Word address (byte address [31:2]) split into line index and tag.
  function automatic logic [29:0] line_index(input logic [29:0] word_addr,
                                             input int unsigned index_w);
    return word_addr & ((30'(1) << index_w) - 30'(1));
  endfunction

  function automatic logic [29:0] line_tag(input logic [29:0] word_addr,
                                           input int unsigned index_w);
    return word_addr >> index_w;
  endfunction

endpackage

// File: rtl/inst_line_array.sv
// Direct-mapped, one-word-per-line instruction store: async read, sync write, sync clear-all.
module inst_line_array
  import inst_fetch_pkg::*;
#(
  parameter int unsigned NumLines = 16,
  parameter int unsigned TagW     = 26
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [$clog2(NumLines)-1:0] rd_index,
  output logic                        rd_valid,
  output logic [TagW-1:0]             rd_tag,
  output logic [INST_W-1:0]           rd_data,
  input  logic                        wr_en,
  input  logic [$clog2(NumLines)-1:0] wr_index,
  input  logic [TagW-1:0]             wr_tag,
  input  logic [INST_W-1:0]           wr_data
);

  logic [NumLines-1:0] valid_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [INST_W-1:0]   data_q [NumLines];

  // Clear beats a same-cycle write so a flush can never leave a stale line valid.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/inst_fetch_responder.sv
// Responder end of the way0 fetch handshake: buffer lookup, refill over req/ack, one-cycle dataOk.
module inst_fetch_responder
  import inst_fetch_pkg::*;
#(
  parameter int unsigned NUM_LINES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              request_i,
  input  logic [31:0]       instAddr_i,
  input  logic              cancel_i,
  input  logic              flush_i,
  output logic              dataOk_o,
  output logic [INST_W-1:0] inst_o,
  output logic              memReq_o,
  output logic [31:0]       memAddr_o,
  input  logic              memAck_i,
  input  logic [INST_W-1:0] memData_i
);

  localparam int unsigned INDEX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = 30 - INDEX_W;

  fetch_state_e      state_q;
  logic [29:0]       addr_q;
  logic              drop_q;
  logic              no_alloc_q;
  logic              data_ok_q;
  logic              mem_req_q;
  logic [INST_W-1:0] inst_q;
  logic [31:0]       mem_addr_q;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [INST_W-1:0]  rd_data;
  logic               hit;
  logic               fill_en;

  assign index = INDEX_W'(line_index(addr_q, INDEX_W));
  assign tag   = TAG_W'(line_tag(addr_q, INDEX_W));

  // A flush in the lookup cycle invalidates the line we would otherwise hit.
  assign hit     = rd_valid && (rd_tag == tag) && !flush_i;
  assign fill_en = (state_q == REFILL) && memAck_i && !no_alloc_q && !flush_i;

  inst_line_array #(
    .NumLines (NUM_LINES),
    .TagW     (TAG_W)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush_i),
    .rd_index (index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill_en),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_data  (memData_i)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      drop_q     <= 1'b0;
      no_alloc_q <= 1'b0;
      data_ok_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      inst_q     <= '0;
      mem_addr_q <= '0;
    end else begin
      data_ok_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (request_i && !cancel_i) begin
            addr_q  <= instAddr_i[31:2];
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (cancel_i) begin
            state_q <= IDLE;
          end else if (hit) begin
            inst_q    <= rd_data;
            data_ok_q <= 1'b1;
            state_q   <= RESP;
          end else begin
            mem_addr_q <= {addr_q, 2'b00};
            mem_req_q  <= 1'b1;
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          // The memory read always runs to completion; cancel only drops the response.
          if (memAck_i) begin
            mem_req_q  <= 1'b0;
            inst_q     <= memData_i;
            drop_q     <= 1'b0;
            no_alloc_q <= 1'b0;
            if (drop_q || cancel_i) begin
              state_q <= IDLE;
            end else begin
              data_ok_q <= 1'b1;
              state_q   <= RESP;
            end
          end else begin
            if (cancel_i) drop_q <= 1'b1;
            if (flush_i)  no_alloc_q <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dataOk_o  = data_ok_q;
  assign inst_o    = inst_q;
  assign memReq_o  = mem_req_q;
  assign memAddr_o = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder: vector table of fetches plus cancel/flush/reset sequences.
module tb_inst_fetch_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        request_i = 1'b0;
  logic [31:0] instAddr_i = '0;
  logic        cancel_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        dataOk_o;
  logic [31:0] inst_o;
  logic        memReq_o;
  logic [31:0] memAddr_o;
  logic        memAck_i = 1'b0;
  logic [31:0] memData_i = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_responder #(
    .NUM_LINES (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .request_i (request_i),
    .instAddr_i(instAddr_i),
    .cancel_i  (cancel_i),
    .flush_i   (flush_i),
    .dataOk_o  (dataOk_o),
    .inst_o    (inst_o),
    .memReq_o  (memReq_o),
    .memAddr_o (memAddr_o),
    .memAck_i  (memAck_i),
    .memData_i (memData_i)
  );

  typedef struct {
    logic [31:0] addr;
    bit          miss;
    logic [31:0] mem_data;
    int unsigned delay;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts in an IDLE cycle N; returns in the IDLE cycle after the transaction.
  task automatic do_fetch(input string name, input logic [31:0] addr, input bit exp_miss,
                          input logic [31:0] mem_data, input int unsigned delay,
                          input int flush_at, input logic [31:0] exp_inst);
    request_i  = 1'b1;
    instAddr_i = addr;
    tick();
    check({name, " lookup dataOk"}, 32'(dataOk_o), 32'd0);
    check({name, " lookup memReq"}, 32'(memReq_o), 32'd0);
    tick();
    if (!exp_miss) begin
      check({name, " hit dataOk"}, 32'(dataOk_o), 32'd1);
      check({name, " hit inst"}, inst_o, exp_inst);
      check({name, " hit memReq"}, 32'(memReq_o), 32'd0);
    end else begin
      check({name, " miss dataOk"}, 32'(dataOk_o), 32'd0);
      check({name, " miss memReq"}, 32'(memReq_o), 32'd1);
      check({name, " miss memAddr"}, memAddr_o, {addr[31:2], 2'b00});
      for (int i = 0; i < int'(delay); i++) begin
        if (i == flush_at) flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check({name, " memReq held"}, 32'(memReq_o), 32'd1);
      end
      memAck_i  = 1'b1;
      memData_i = mem_data;
      tick();
      memAck_i  = 1'b0;
      memData_i = '0;
      check({name, " refill dataOk"}, 32'(dataOk_o), 32'd1);
      check({name, " refill inst"}, inst_o, exp_inst);
      check({name, " refill memReq"}, 32'(memReq_o), 32'd0);
    end
    request_i = 1'b0;
    tick();
    check({name, " strobe width"}, 32'(dataOk_o), 32'd0);
  endtask

  initial begin
    // Index is addr[5:2]; 0x04 and 0x44 share line 1.
    vecs[0] = '{32'h8000_0000, 1'b1, 32'h0000_0013, 3, 32'h0000_0013};
    vecs[1] = '{32'h8000_0000, 1'b0, 32'h0,         0, 32'h0000_0013};
    vecs[2] = '{32'h8000_0004, 1'b1, 32'h0000_00A1, 2, 32'h0000_00A1};
    vecs[3] = '{32'h8000_0044, 1'b1, 32'h0000_00B2, 1, 32'h0000_00B2};
    vecs[4] = '{32'h8000_0004, 1'b1, 32'h0000_00C3, 2, 32'h0000_00C3};
    vecs[5] = '{32'h8000_0044, 1'b1, 32'h0000_00B2, 0, 32'h0000_00B2};
    vecs[6] = '{32'h8000_0008, 1'b1, 32'h0000_0008, 0, 32'h0000_0008};
    vecs[7] = '{32'h8000_000C, 1'b1, 32'h0000_000C, 1, 32'h0000_000C};
    vecs[8] = '{32'h8000_0008, 1'b0, 32'h0,         0, 32'h0000_0008};

    tick();
    check("reset dataOk", 32'(dataOk_o), 32'd0);
    check("reset inst", inst_o, 32'd0);
    check("reset memReq", 32'(memReq_o), 32'd0);
    check("reset memAddr", memAddr_o, 32'd0);
    tick();
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      do_fetch($sformatf("vec%0d", v), vecs[v].addr, vecs[v].miss, vecs[v].mem_data,
               vecs[v].delay, -1, vecs[v].exp_inst);
    end

    // Warm 0x0..0xC, flush, every re-fetch must miss.
    do_fetch("warm4", 32'h8000_0004, 1'b1, 32'h0000_00A1, 1, -1, 32'h0000_00A1);
    do_fetch("warm4 hit", 32'h8000_0004, 1'b0, 32'h0, 0, -1, 32'h0000_00A1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      do_fetch($sformatf("postflush%0d", a), 32'h8000_0000 + 32'(a * 4), 1'b1,
               32'h0000_1000 + 32'(a), 1, -1, 32'h0000_1000 + 32'(a));
    end

    // Flush during refill: response delivered, line not allocated.
    do_fetch("flush refill", 32'h8000_0010, 1'b1, 32'h0000_0055, 3, 1, 32'h0000_0055);
    do_fetch("flush noalloc", 32'h8000_0010, 1'b1, 32'h0000_0056, 1, -1, 32'h0000_0056);

    // Cancel together with request in IDLE: nothing latched.
    request_i  = 1'b1;
    cancel_i   = 1'b1;
    instAddr_i = 32'h8000_0200;
    tick();
    request_i = 1'b0;
    cancel_i  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle cancel memReq", 32'(memReq_o), 32'd0);
      check("idle cancel dataOk", 32'(dataOk_o), 32'd0);
    end

    // Cancel one cycle after memReq rises: read completes, no response.
    request_i  = 1'b1;
    instAddr_i = 32'h8000_0100;
    tick();
    tick();
    check("refill cancel memReq rise", 32'(memReq_o), 32'd1);
    tick();
    cancel_i  = 1'b1;
    request_i = 1'b0;
    check("refill cancel memReq N+3", 32'(memReq_o), 32'd1);
    tick();
    cancel_i = 1'b0;
    check("refill cancel memReq N+4", 32'(memReq_o), 32'd1);
    memAck_i  = 1'b1;
    memData_i = 32'h0000_0077;
    tick();
    memAck_i  = 1'b0;
    memData_i = '0;
    check("refill cancel memReq drop", 32'(memReq_o), 32'd0);
    check("refill cancel dataOk", 32'(dataOk_o), 32'd0);
    tick();
    check("refill cancel dataOk late", 32'(dataOk_o), 32'd0);
    do_fetch("post cancel hit", 32'h8000_0100, 1'b0, 32'h0, 0, -1, 32'h0000_0077);

    // Cancel arriving with the hit decision: no strobe, back to IDLE.
    request_i  = 1'b1;
    instAddr_i = 32'h8000_0100;
    tick();
    cancel_i  = 1'b1;
    request_i = 1'b0;
    tick();
    cancel_i = 1'b0;
    check("hit cancel dataOk", 32'(dataOk_o), 32'd0);
    check("hit cancel memReq", 32'(memReq_o), 32'd0);
    tick();
    check("hit cancel dataOk late", 32'(dataOk_o), 32'd0);
    do_fetch("post hit cancel", 32'h8000_0100, 1'b0, 32'h0, 0, -1, 32'h0000_0077);

    // Reset mid-refill, then a stray ack.
    request_i  = 1'b1;
    instAddr_i = 32'h8000_0020;
    tick();
    tick();
    check("rst refill memReq", 32'(memReq_o), 32'd1);
    reset     = 1'b1;
    request_i = 1'b0;
    tick();
    reset = 1'b0;
    check("rst memReq", 32'(memReq_o), 32'd0);
    check("rst dataOk", 32'(dataOk_o), 32'd0);
    check("rst inst", inst_o, 32'd0);
    memAck_i  = 1'b1;
    memData_i = 32'hDEAD_BEEF;
    tick();
    memAck_i  = 1'b0;
    memData_i = '0;
    check("stray ack dataOk", 32'(dataOk_o), 32'd0);
    tick();
    check("stray ack dataOk late", 32'(dataOk_o), 32'd0);
    check("stray ack memReq", 32'(memReq_o), 32'd0);
    do_fetch("post reset miss", 32'h8000_0000, 1'b1, 32'h0000_0099, 1, -1, 32'h0000_0099);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
